// File: rtl/mm_load_ctrl.sv
// mm_load_ctrl: serial matrix loader and SRAM write sequencer.
// Captures matrix indices and launches the MAC core via start/done.
module mm_load_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              matrix,
  input  logic [1:0]        matrix_size,
  input  logic              in_valid2,
  input  logic              i_mat_idx,
  input  logic              w_mat_idx,
  input  logic              done,
  output logic              sram_we,
  output logic              sram_sel,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic [1:0]        size_r,
  output logic [ADDR_W-1:0] i_base,
  output logic [ADDR_W-1:0] w_base,
  output logic              start,
  output logic              busy
);

  localparam int BW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_X, S_LOAD_W, S_READY,
    S_IDX, S_START, S_BUSY
  } state_e;

  state_e            state_q, state_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] sh_q, sh_d, sh_nx;
  logic [3:0]        ix_q, ix_d, wx_q, wx_d;
  logic [1:0]        icnt_q, icnt_d;
  logic              we_q, we_d, sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] ib_q, ib_d, wb_q, wb_d;
  logic              start_q, start_d;
  logic [2:0]        shamt;
  logic [ADDR_W-1:0] last_w;

  // log2(NN) and last word index of one bank (16*NN-1)
  always_comb begin
    unique case (size_q)
      2'd0:    shamt = 3'd2;
      2'd1:    shamt = 3'd4;
      default: shamt = 3'd6;
    endcase
    last_w = (ADDR_W'(16) << shamt) - ADDR_W'(1);
    sh_nx  = {sh_q[DATA_W-2:0], matrix};
  end

  // next-state, counters and registered outputs
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    word_d  = word_q;
    sh_d    = sh_q;
    ix_d    = ix_q;
    wx_d    = wx_q;
    icnt_d  = icnt_q;
    we_d    = 1'b0;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    size_d  = size_q;
    ib_d    = ib_q;
    wb_d    = wb_q;
    start_d = 1'b0;
    unique case (state_q)
      S_IDLE, S_READY: begin
        if (in_valid) begin
          state_d = S_LOAD_X;
          size_d  = matrix_size;
          sh_d    = {{(DATA_W-1){1'b0}}, matrix};
          bit_d   = BW'(1);
          word_d  = '0;
        end else if (state_q == S_READY && in_valid2) begin
          state_d = S_IDX;
          ix_d    = {3'b000, i_mat_idx};
          wx_d    = {3'b000, w_mat_idx};
          icnt_d  = 2'd1;
        end
      end
      S_LOAD_X, S_LOAD_W: begin
        if (!in_valid) begin
          state_d = S_IDLE;
          bit_d   = '0;
          word_d  = '0;
        end else begin
          sh_d  = sh_nx;
          bit_d = bit_q + BW'(1);
          if (bit_q == BW'(DATA_W-1)) begin
            bit_d  = '0;
            we_d   = 1'b1;
            sel_d  = (state_q == S_LOAD_W);
            addr_d = word_q;
            wdat_d = sh_nx;
            word_d = word_q + ADDR_W'(1);
            if (word_q == last_w) begin
              word_d  = '0;
              state_d = (state_q == S_LOAD_X) ? S_LOAD_W : S_READY;
            end
          end
        end
      end
      S_IDX: begin
        if (in_valid2) begin
          ix_d   = {ix_q[2:0], i_mat_idx};
          wx_d   = {wx_q[2:0], w_mat_idx};
          icnt_d = icnt_q + 2'd1;
          if (icnt_q == 2'd3) state_d = S_START;
        end
      end
      S_START: begin
        ib_d    = ADDR_W'(ix_q) << shamt;
        wb_d    = ADDR_W'(wx_q) << shamt;
        start_d = 1'b1;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        if (done) state_d = S_READY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      word_q  <= '0;
      sh_q    <= '0;
      ix_q    <= '0;
      wx_q    <= '0;
      icnt_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      size_q  <= '0;
      ib_q    <= '0;
      wb_q    <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      sh_q    <= sh_d;
      ix_q    <= ix_d;
      wx_q    <= wx_d;
      icnt_q  <= icnt_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      size_q  <= size_d;
      ib_q    <= ib_d;
      wb_q    <= wb_d;
      start_q <= start_d;
    end
  end

  assign sram_we    = we_q;
  assign sram_sel   = sel_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdat_q;
  assign size_r     = size_q;
  assign i_base     = ib_q;
  assign w_base     = wb_q;
  assign start      = start_q;
  assign busy       = (state_q == S_BUSY);

endmodule
